mov_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 32-bit register-move path among NUM_REQ requesters (decode slots, load return, debug port) and drives a single register-file write port.
- Each winning request is copied bit-exact into a registered output stage with one cycle of latency.
- Honours write-port backpressure via wr_stall.
- Sits between the requesters and the register file write port, replacing direct fan-in to the move unit.

---
 rtl/mov_arbiter.sv | 102 ++++++++++
 tb/tb_mov_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mov_arbiter.sv
// Round-robin arbiter feeding one register-file write port through a single registered slot.
// Define MOV_ARB_LOCK_EN to add req_lock, which lets a requester hold the grant across several moves.
module mov_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*ADDR_W-1:0] req_dst,
`ifdef MOV_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        req_lock,
`endif
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic [IDX_W-1:0]          wr_src,
    input  logic                      wr_stall
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] next_ptr;
    logic             found;
    logic             slot_free;
    logic             xfer;
    int               scan_idx;

`ifdef MOV_ARB_LOCK_EN
    logic             locked;
    logic [IDX_W-1:0] lock_idx;
`endif

    assign slot_free = (state == EMPTY) || !wr_stall;
    assign wr_en     = (state == FULL);

    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = IDX_W'(scan_idx);
            end
        end
`ifdef MOV_ARB_LOCK_EN
        // A held lock overrides the round-robin scan entirely.
        if (locked) begin
            found  = req_valid[lock_idx];
            winner = lock_idx;
        end
`endif
    end

    // Gating with rst keeps req_ready quiet while reset is asserted.
    assign xfer      = found && slot_free && !rst;
    assign req_ready = xfer ? (NUM_REQ'(1) << winner) : '0;
    assign next_ptr  = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            wr_addr <= '0;
            wr_data <= '0;
            wr_src  <= '0;
            rr_ptr  <= '0;
`ifdef MOV_ARB_LOCK_EN
            locked   <= 1'b0;
            lock_idx <= '0;
`endif
        end else if (xfer) begin
            state   <= FULL;
            wr_addr <= req_dst[int'(winner)*ADDR_W +: ADDR_W];
            wr_data <= req_data[int'(winner)*DATA_W +: DATA_W];
            wr_src  <= winner;
`ifdef MOV_ARB_LOCK_EN
            if (req_lock[winner]) begin
                locked   <= 1'b1;
                lock_idx <= winner;
            end else begin
                locked <= 1'b0;
                rr_ptr <= next_ptr;
            end
`else
            rr_ptr <= next_ptr;
`endif
        end else if (slot_free) begin
            // Payload registers keep their last values after the drain.
            state <= EMPTY;
        end
    end

endmodule

// File: tb/tb_mov_arbiter.sv
// Self-checking bench for mov_arbiter: directed literal checks plus a randomized run
// compared every cycle against a behavioural model of the arbitration rules.
module tb_mov_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int IDX_W   = 2;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_dst = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [DATA_W-1:0]         wr_data;
    logic [IDX_W-1:0]          wr_src;
    logic                      wr_stall = 1'b0;
`ifdef MOV_ARB_LOCK_EN
    logic [NUM_REQ-1:0]        req_lock = '0;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    mov_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_dst(req_dst),
`ifdef MOV_ARB_LOCK_EN
        .req_lock(req_lock),
`endif
        .req_ready(req_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_src(wr_src), .wr_stall(wr_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a);
        req_data[i*DATA_W +: DATA_W] = d;
        req_dst[i*ADDR_W +: ADDR_W]  = a;
    endtask

    // Behavioural model: state after the most recent edge.
    bit                 mv = 0;
    bit                 m_full;
    int                 m_ptr;
    logic [ADDR_W-1:0]  m_addr;
    logic [DATA_W-1:0]  m_data;
    int                 m_src;
`ifdef MOV_ARB_LOCK_EN
    bit                 m_locked;
    int                 m_lidx;
`endif
    bit                 m_fnd, m_free, m_grant;
    int                 m_w;
    logic [NUM_REQ-1:0] e_rdy;

    always @(negedge clk) begin
        m_fnd  = 0;
        m_w    = 0;
        m_free = !m_full || !wr_stall;
        for (int o = 0; o < NUM_REQ; o++)
            if (!m_fnd && req_valid[(m_ptr + o) % NUM_REQ]) begin
                m_fnd = 1;
                m_w   = (m_ptr + o) % NUM_REQ;
            end
`ifdef MOV_ARB_LOCK_EN
        if (m_locked) begin
            m_fnd = req_valid[m_lidx];
            m_w   = m_lidx;
        end
`endif
        m_grant = m_fnd && m_free && !rst;
        e_rdy   = m_grant ? (NUM_REQ'(1) << m_w) : '0;
        if (mv) begin
            chk("model_req_ready", 64'(req_ready), 64'(e_rdy));
            chk("model_wr_en",     64'(wr_en),     64'(m_full));
            chk("model_wr_addr",   64'(wr_addr),   64'(m_addr));
            chk("model_wr_data",   64'(wr_data),   64'(m_data));
            chk("model_wr_src",    64'(wr_src),    64'(m_src));
        end
        if (rst) begin
            mv = 1; m_full = 0; m_ptr = 0; m_addr = '0; m_data = '0; m_src = 0;
`ifdef MOV_ARB_LOCK_EN
            m_locked = 0; m_lidx = 0;
`endif
        end else if (m_grant) begin
            m_full = 1;
            m_addr = req_dst[m_w*ADDR_W +: ADDR_W];
            m_data = req_data[m_w*DATA_W +: DATA_W];
            m_src  = m_w;
`ifdef MOV_ARB_LOCK_EN
            if (req_lock[m_w]) begin
                m_locked = 1; m_lidx = m_w;
            end else begin
                m_locked = 0; m_ptr = (m_w + 1) % NUM_REQ;
            end
`else
            m_ptr = (m_w + 1) % NUM_REQ;
`endif
        end else if (m_free) begin
            m_full = 0;
        end
    end

    initial begin
        // Reset with every requester asking
        rst = 1; req_valid = 4'b1111;
        tick(); tick(); #1;
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_wr_en", 64'(wr_en), 64'h0);
        chk("rst_wr_data", 64'(wr_data), 64'h0);
        chk("rst_wr_src", 64'(wr_src), 64'h0);
        rst = 0; #1;

        // Fairness: 0,1,2,3,0,1,2,3 with back-to-back writes
        for (int k = 0; k < 8; k++) begin
            chk("fair_ready", 64'(req_ready), 64'(1 << (k % 4)));
            tick(); #1;
            chk("fair_wr_en", 64'(wr_en), 64'h1);
            chk("fair_wr_src", 64'(wr_src), 64'(k % 4));
        end
        req_valid = '0; #1;
        chk("idle_ready", 64'(req_ready), 64'h0);
        tick(); #1;
        chk("drain_wr_en", 64'(wr_en), 64'h0);

        // Data path through requester 2
        set_req(2, 32'hDEADBEEF, 5'd17); req_valid = 4'b0100; #1;
        chk("dp_ready", 64'(req_ready), 64'h4);
        tick(); req_valid = '0; #1;
        chk("dp_wr_en", 64'(wr_en), 64'h1);
        chk("dp_wr_addr", 64'(wr_addr), 64'd17);
        chk("dp_wr_data", 64'(wr_data), 64'hDEADBEEF);
        chk("dp_wr_src", 64'(wr_src), 64'h2);
        tick(); #1;
        chk("dp_drain_wr_en", 64'(wr_en), 64'h0);
        chk("dp_hold_data", 64'(wr_data), 64'hDEADBEEF);

        // Wrap: pointer sits at 3
        req_valid = 4'b1001; #1;
        chk("wrap_ready3", 64'(req_ready), 64'h8);
        tick(); #1;
        chk("wrap_src3", 64'(wr_src), 64'h3);
        chk("wrap_ready0", 64'(req_ready), 64'h1);
        tick(); #1;
        chk("wrap_src0", 64'(wr_src), 64'h0);
        req_valid = '0;
        tick();

        // Stall holds the slot and blocks grants
        set_req(1, 32'hA5A5A5A5, 5'd3); req_valid = 4'b0010;
        tick();
        set_req(0, 32'h12345678, 5'd9); wr_stall = 1; req_valid = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_ready", 64'(req_ready), 64'h0);
            chk("stall_wr_en", 64'(wr_en), 64'h1);
            chk("stall_data", 64'(wr_data), 64'hA5A5A5A5);
            chk("stall_src", 64'(wr_src), 64'h1);
            tick();
        end
        wr_stall = 0; #1;
        chk("unstall_ready", 64'(req_ready), 64'h1);
        tick(); #1;
        chk("unstall_data", 64'(wr_data), 64'h12345678);
        chk("unstall_addr", 64'(wr_addr), 64'd9);
        chk("unstall_src", 64'(wr_src), 64'h0);
        req_valid = '0;
        tick();

`ifdef MOV_ARB_LOCK_EN
        // Pointer now at 1: requester 1 locks for two moves then releases
        req_valid = 4'b1111; req_lock = 4'b0010;
        for (int g = 0; g < 3; g++) begin
            if (g == 2) req_lock = '0;
            #1;
            chk("lock_ready", 64'(req_ready), 64'h2);
            tick();
        end
        #1;
        chk("unlock_ready", 64'(req_ready), 64'h4);
        req_valid = '0; req_lock = '0;
        tick();
`endif

        // Randomized traffic checked by the model
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst       = ($urandom_range(0, 99) == 0);
            wr_stall  = ($urandom_range(0, 2) == 0);
            req_valid = NUM_REQ'($urandom);
`ifdef MOV_ARB_LOCK_EN
            req_lock  = NUM_REQ'($urandom) & NUM_REQ'($urandom);
`endif
            for (int i = 0; i < NUM_REQ; i++)
                set_req(i, DATA_W'($urandom), ADDR_W'($urandom));
        end
        rst = 0; req_valid = '0; wr_stall = 0;
        tick(); tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
